hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller. It is the producer of the stall/flush control that the ID/EX, IF/ID and PC registers consume.
- It detects load-use hazards between the ID and EX stages and sequences control-flow redirects resolved in EX.
- It drives bubble/flush requests so that an inserted slot carries all-zero control.
- It keeps saturating performance counters of stall and flush cycles for the debug/CSR path.

Parameters:
- REDIRECT_BUBBLES, 1, extra cycles after a redirect for which IF/ID stays flushed (covers synchronous I-mem latency); legal range 0..7.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt as a source (R-type, store, beq/bne).
- ex_mem_read  in  1  the EX-stage instruction is a load.
- ex_rt  in  5  destination register of the EX-stage load.
- ex_redirect  in  1  branch taken, j, jal or jr resolved in EX this cycle.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID.
- if_id_flush  out  1  zero IF/ID (NOP).
- id_ex_stall  out  1  insert a bubble into ID/EX (control cleared).
- id_ex_flush  out  1  kill the ID/EX entry (control cleared).
- stall_cycles  out  CNT_W  count of load-use stall cycles.
- flush_cycles  out  CNT_W  count of cycles with if_id_flush=1.

Behaviour:
- State machine (one-hot or encoded; the encoding is free): RUN, LU_STALL, REDIR.
- Detection is combinational on the current inputs plus the current state (Mealy). There is zero-cycle latency from inputs to stall/flush outputs.
- load_use = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
- RUN:
  - If ex_redirect: if_id_flush=1, id_ex_flush=1, pc_stall=0. Load the bubble counter with REDIRECT_BUBBLES. Next state is REDIR if REDIRECT_BUBBLES>0, else RUN.
  - Else if load_use: pc_stall=1, if_id_stall=1, id_ex_stall=1. Next state is LU_STALL.
  - Else all outputs are 0 and the state stays RUN.
- LU_STALL:
  - This state exists for exactly one cycle, because the bubble has already cleared ex_mem_read.
  - load_use is re-evaluated here. A second load (an impossible double-load chain) asserts the stall again and the state stays LU_STALL.
  - ex_redirect takes priority exactly as in RUN.
  - Otherwise all outputs are 0 and the next state is RUN.
- REDIR:
  - if_id_flush=1 every cycle. pc_stall=0. id_ex_stall=0 and id_ex_flush=0 (the flushed NOP propagates naturally).
  - The counter decrements each cycle. When the counter is 1, the next state is RUN.
  - load_use is suppressed, because the ID stage holds a NOP.
  - A new ex_redirect reloads the counter, asserts id_ex_flush, and the state remains REDIR.
- Priority: redirect over load-use, always. When both are true in the same cycle, the outputs are the redirect outputs only, and stall_cycles does not increment.
- Counters:
  - stall_cycles increments in each cycle with id_ex_stall=1.
  - flush_cycles increments in each cycle with if_id_flush=1.
  - Both saturate at all-ones and never wrap.
- Reset (asynchronous, reset_n=0): state=RUN, bubble counter=0, stall_cycles=0, flush_cycles=0.
  - All stall/flush outputs are 0 while reset_n=0, regardless of the inputs.
  - Reset mid-REDIR abandons the remaining bubbles.
- All registers are in one clocked process on posedge clk / negedge reset_n. Outputs come from combinational logic driven by the registers and the inputs.

Decomposition:
- pipe_ctrl_pkg holds:
  - typedef enum hz_state_t {RUN, LU_STALL, REDIR};
  - localparam REG_ZERO = 5'd0;
  - the register-index width REG_W = 5.
- One sub-module, sat_counter (parameter W; inputs clk, reset_n, inc; output count), instantiated twice for the performance counters.

Test Plan:
- Load-use on rs: ex_mem_read=1, ex_rt=8, id_rs=8. Required in the same cycle: pc_stall=if_id_stall=id_ex_stall=1. Next cycle (ex_mem_read=0): all outputs 0. stall_cycles=1.
- Load-use on rt gating:
  - ex_rt=9, id_rt=9, id_uses_rt=0 -> no stall.
  - Same with id_uses_rt=1 -> stall asserted.
  - ex_rt=0, id_rs=0 -> no stall.
- Redirect with REDIRECT_BUBBLES=2: ex_redirect pulse at cycle T. Required:
  - T: if_id_flush=1, id_ex_flush=1.
  - T+1 and T+2: if_id_flush=1 only.
  - T+3: all 0.
  - flush_cycles=3.
- Simultaneous redirect and load_use: redirect outputs only, pc_stall=0, stall_cycles unchanged.
- Back-to-back redirect: second ex_redirect arriving in the first REDIR cycle restarts the count. if_id_flush stays 1 for REDIRECT_BUBBLES more cycles after the second pulse.
- Reset and saturation:
  - reset_n low mid-REDIR -> outputs 0 immediately, counters 0, state RUN after release.
  - With CNT_W=4, 20 stall cycles -> stall_cycles=15 and holds.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline control slice.
//   hz_state_t : hazard controller state (RUN, LU_STALL, REDIR)
//   REG_W      : register-index width of the pipeline
//   REG_ZERO   : index of the hard-wired zero register
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    REDIR    = 2'd2
  } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk     in  clock
//   reset_n in  asynchronous active-low reset (clears count)
//   inc     in  count this cycle
//   count   out current value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Increment on request, but hold once every bit is set so the debug
  // path never sees a small number after a long run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller: load-use stall detection between ID and EX,
// redirect (branch/jump) flush sequencing, and saturating stall/flush
// performance counters.
//   clk          in  pipeline clock
//   reset_n      in  asynchronous active-low reset
//   id_rs        in  rs field of the ID instruction
//   id_rt        in  rt field of the ID instruction
//   id_uses_rt   in  ID instruction reads rt as a source
//   ex_mem_read  in  EX instruction is a load
//   ex_rt        in  destination register of the EX load
//   ex_redirect  in  control-flow redirect resolved in EX this cycle
//   pc_stall     out hold PC
//   if_id_stall  out hold IF/ID
//   if_id_flush  out zero IF/ID
//   id_ex_stall  out insert a bubble into ID/EX
//   id_ex_flush  out kill the ID/EX entry
//   stall_cycles out number of load-use stall cycles (saturating)
//   flush_cycles out number of IF/ID flush cycles (saturating)
// ---------------------------------------------------------------------------
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REDIRECT_BUBBLES = 1,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_redirect,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  localparam logic [2:0] BUBBLE_LOAD = 3'(REDIRECT_BUBBLES);
  localparam logic       HAS_BUBBLES = (REDIRECT_BUBBLES > 0);

  hz_state_t  state;
  hz_state_t  next_state;
  logic [2:0] bub_cnt;
  logic [2:0] next_bub_cnt;

  logic load_use;
  logic raw_pc_stall;
  logic raw_if_id_stall;
  logic raw_if_id_flush;
  logic raw_id_ex_stall;
  logic raw_id_ex_flush;

  // A load in EX whose destination feeds the ID instruction; writes to the
  // zero register never create a dependency.
  assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // Mealy decode of the controls and next state. A redirect always wins over
  // a load-use hazard, and in REDIR the ID stage holds a flushed NOP, so any
  // apparent load-use there is ignored.
  always_comb begin
    next_state      = state;
    next_bub_cnt    = bub_cnt;
    raw_pc_stall    = 1'b0;
    raw_if_id_stall = 1'b0;
    raw_if_id_flush = 1'b0;
    raw_id_ex_stall = 1'b0;
    raw_id_ex_flush = 1'b0;

    unique case (state)
      REDIR: begin
        raw_if_id_flush = 1'b1;
        if (ex_redirect) begin
          raw_id_ex_flush = 1'b1;
          next_bub_cnt    = BUBBLE_LOAD;
          next_state      = REDIR;
        end else begin
          next_bub_cnt = bub_cnt - 3'd1;
          if (bub_cnt <= 3'd1) begin
            next_state = RUN;
          end
        end
      end

      default: begin
        if (ex_redirect) begin
          raw_if_id_flush = 1'b1;
          raw_id_ex_flush = 1'b1;
          next_bub_cnt    = BUBBLE_LOAD;
          next_state      = HAS_BUBBLES ? REDIR : RUN;
        end else if (load_use) begin
          raw_pc_stall    = 1'b1;
          raw_if_id_stall = 1'b1;
          raw_id_ex_stall = 1'b1;
          next_state      = LU_STALL;
        end else begin
          next_state = RUN;
        end
      end
    endcase
  end

  // Controls are forced low while reset is held so a half-initialised
  // pipeline never sees a stall or flush request.
  assign pc_stall    = raw_pc_stall    & reset_n;
  assign if_id_stall = raw_if_id_stall & reset_n;
  assign if_id_flush = raw_if_id_flush & reset_n;
  assign id_ex_stall = raw_id_ex_stall & reset_n;
  assign id_ex_flush = raw_id_ex_flush & reset_n;

  // State and bubble counter. Reset drops any pending redirect bubbles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RUN;
      bub_cnt <= 3'd0;
    end else begin
      state   <= next_state;
      bub_cnt <= next_bub_cnt;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (id_ex_stall),
    .count   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (if_id_flush),
    .count   (flush_cycles)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl with REDIRECT_BUBBLES=2 and CNT_W=4.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int CW  = 4;
  localparam int SAT = 15;

  logic          clk;
  logic          reset_n;
  logic [4:0]    id_rs;
  logic [4:0]    id_rt;
  logic          id_uses_rt;
  logic          ex_mem_read;
  logic [4:0]    ex_rt;
  logic          ex_redirect;
  logic          pc_stall;
  logic          if_id_stall;
  logic          if_id_flush;
  logic          id_ex_stall;
  logic          id_ex_flush;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] flush_cycles;

  int total;
  int bad;

  // One vector: inputs plus expected
  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush}.
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       mem_read;
    logic [4:0] ert;
    logic       redirect;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs [22];

  hazard_ctrl #(.REDIRECT_BUBBLES(2), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .ex_redirect  (ex_redirect),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_stall  (id_ex_stall),
    .id_ex_flush  (id_ex_flush),
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic uses_rt, input logic mem_read,
                              input logic [4:0] ert, input logic redirect,
                              input logic [4:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.mem_read = mem_read;
    v.ert = ert; v.redirect = redirect; v.exp = exp;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    id_rs       = v.rs;
    id_rt       = v.rt;
    id_uses_rt  = v.uses_rt;
    ex_mem_read = v.mem_read;
    ex_rt       = v.ert;
    ex_redirect = v.redirect;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkCtl(input string tag, input logic [4:0] exp);
    checkOutput({tag, ".pc_stall"},    32'(pc_stall),    32'(exp[4]));
    checkOutput({tag, ".if_id_stall"}, 32'(if_id_stall), 32'(exp[3]));
    checkOutput({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(exp[2]));
    checkOutput({tag, ".id_ex_stall"}, 32'(id_ex_stall), 32'(exp[1]));
    checkOutput({tag, ".id_ex_flush"}, 32'(id_ex_flush), 32'(exp[0]));
  endtask

  function automatic int sat(input int x);
    return (x > SAT) ? SAT : x;
  endfunction

  // Directed table from reset with REDIRECT_BUBBLES=2, then hand-written
  // sequences for reset mid-REDIR and counter saturation.
  initial begin
    int exp_stall;
    int exp_flush;
    vec_t idle;
    vec_t lu;
    vec_t redir;

    total = 0;
    bad   = 0;
    idle  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b00000);
    lu    = mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 5'b11010);
    redir = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'b00101);

    vecs[0]  = idle;
    vecs[1]  = lu;
    vecs[2]  = mk(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0, 5'b00000);
    vecs[3]  = mk(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 5'b00000);
    vecs[4]  = mk(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 5'b11010);
    vecs[5]  = mk(5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 5'b11010);
    vecs[6]  = mk(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'b00000);
    vecs[7]  = mk(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'b00000);
    vecs[8]  = redir;
    vecs[9]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b00100);
    vecs[10] = mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 5'b00100);
    vecs[11] = idle;
    vecs[12] = mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 5'b00101);
    vecs[13] = redir;
    vecs[14] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b00100);
    vecs[15] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b00100);
    vecs[16] = idle;
    vecs[17] = lu;
    vecs[18] = mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 5'b00101);
    vecs[19] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b00100);
    vecs[20] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'b00100);
    vecs[21] = idle;

    reset_n = 1'b0;
    applyStimulus(idle);
    #1;
    checkCtl("reset", 5'b00000);
    checkOutput("reset.stall_cycles", 32'(stall_cycles), 32'd0);
    checkOutput("reset.flush_cycles", 32'(flush_cycles), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkCtl($sformatf("vec%0d", i), vecs[i].exp);
      checkOutput($sformatf("vec%0d.stall_cycles", i), 32'(stall_cycles), 32'(sat(exp_stall)));
      checkOutput($sformatf("vec%0d.flush_cycles", i), 32'(flush_cycles), 32'(sat(exp_flush)));
      if (vecs[i].exp[1]) exp_stall++;
      if (vecs[i].exp[2]) exp_flush++;
      @(posedge clk);
      #1;
    end
    applyStimulus(idle);
    @(negedge clk);
    checkOutput("table.stall_cycles", 32'(stall_cycles), 32'd4);
    checkOutput("table.flush_cycles", 32'(flush_cycles), 32'd10);

    // Reset while in REDIR: outputs drop at once, bubbles are abandoned.
    @(posedge clk);
    #1;
    applyStimulus(redir);
    @(posedge clk);
    #1;
    applyStimulus(idle);
    @(negedge clk);
    checkCtl("redir_pre_reset", 5'b00100);
    @(posedge clk);
    #1;
    applyStimulus(mk(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 5'b00000));
    reset_n = 1'b0;
    #1;
    checkCtl("in_reset", 5'b00000);
    checkOutput("in_reset.stall_cycles", 32'(stall_cycles), 32'd0);
    checkOutput("in_reset.flush_cycles", 32'(flush_cycles), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(idle);
    reset_n = 1'b1;
    @(negedge clk);
    checkCtl("post_reset0", 5'b00000);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkCtl("post_reset1", 5'b00000);

    // Stall counter saturation via a held double-load chain.
    @(posedge clk);
    #1;
    applyStimulus(lu);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput($sformatf("sat_stall%0d.pc_stall", i), 32'(pc_stall), 32'd1);
      checkOutput($sformatf("sat_stall%0d.count", i), 32'(stall_cycles), 32'(sat(i)));
      @(posedge clk);
      #1;
    end
    applyStimulus(idle);
    @(negedge clk);
    checkOutput("sat_stall.final", 32'(stall_cycles), 32'd15);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("sat_stall.hold", 32'(stall_cycles), 32'd15);
    checkOutput("sat_stall.flush_cycles", 32'(flush_cycles), 32'd0);

    // Flush counter saturation via back-to-back redirects.
    @(posedge clk);
    #1;
    applyStimulus(redir);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput($sformatf("sat_flush%0d.id_ex_flush", i), 32'(id_ex_flush), 32'd1);
      checkOutput($sformatf("sat_flush%0d.count", i), 32'(flush_cycles), 32'(sat(i)));
      @(posedge clk);
      #1;
    end
    applyStimulus(idle);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkCtl("sat_flush.settled", 5'b00000);
    checkOutput("sat_flush.final", 32'(flush_cycles), 32'd15);
    checkOutput("sat_flush.stall_hold", 32'(stall_cycles), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
